// File: rtl/fifo_wr_arbiter_if.sv
// Push-side bundle shared by the producers, the write arbiter and the FIFO.
// Handshake: a producer word moves on a rising clock edge when
// req_valid[i] & req_ready[i]; fifo_wr_en is the FIFO push strobe and is
// asserted exactly in the cycles where such a move happens.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;

    // Environment side: producers plus the FIFO full flag.
    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_data_in
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_data_in
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for the CSR FIFO push port. One producer owns
// the port per grant for at most MAX_BURST words; pushes are gated by the
// CONTROL enable bit and the FIFO full flag. Every re-arbitration costs one
// IDLE cycle. A 32-bit counter tracks accepted words for CSR readback.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                fifo_enable,
    input  logic                cnt_clr,
    fifo_wr_arbiter_if.slave    bus,
    output logic [ID_W-1:0]     grant_id,
    output logic                busy,
    output logic [31:0]         xfer_count,
    output logic                dbg_state_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [BC_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [31:0]     xfer_count_q, xfer_count_d;

    logic                  arb_found;
    logic [ID_W-1:0]       arb_owner;
    logic                  owner_valid;
    logic                  owner_last;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  xfer;
    logic [NUM_REQ-1:0]    ready;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  busy_c;
    int                    idx;

    // Round-robin search starting just after the previous owner, with wrap.
    always_comb begin
        arb_found = 1'b0;
        arb_owner = '0;
        idx       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant_q) + i) % NUM_REQ;
            if (!arb_found && bus.req_valid[idx]) begin
                arb_found = 1'b1;
                arb_owner = ID_W'(idx);
            end
        end
    end

    assign owner_valid = bus.req_valid[grant_id_q];
    assign owner_last  = bus.req_last[grant_id_q];
    assign owner_data  = bus.req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];

    // Next-state and handshake outputs; the owner's word passes straight through.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        burst_cnt_d  = burst_cnt_q;
        ready        = '0;
        wr_en        = 1'b0;
        data_out     = '0;
        busy_c       = 1'b0;
        xfer         = 1'b0;
        case (state_q)
            IDLE: begin
                // A full FIFO does not stop arbitration, only the pushes.
                if (fifo_enable && arb_found) begin
                    state_d      = GRANT;
                    grant_id_d   = arb_owner;
                    last_grant_d = arb_owner;
                    burst_cnt_d  = '0;
                end
            end
            GRANT: begin
                busy_c            = 1'b1;
                ready[grant_id_q] = fifo_enable & ~bus.fifo_full;
                xfer              = owner_valid & fifo_enable & ~bus.fifo_full;
                wr_en             = xfer;
                data_out          = owner_data;
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                // Release on end of packet, burst cap, producer drop or disable.
                // A full FIFO with a still-valid owner simply holds the grant.
                if ((xfer && (owner_last || burst_cnt_q == BC_W'(MAX_BURST - 1))) ||
                    !owner_valid || !fifo_enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word counter: a clear coinciding with a push leaves just that push counted.
    always_comb begin
        if (cnt_clr) begin
            xfer_count_d = xfer ? 32'd1 : 32'd0;
        end else if (xfer) begin
            xfer_count_d = xfer_count_q + 32'd1;
        end else begin
            xfer_count_d = xfer_count_q;
        end
    end

    // State registers with asynchronous reset; an in-flight word is dropped.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            burst_cnt_q  <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            burst_cnt_q  <= burst_cnt_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_data_in = data_out;
    assign grant_id         = grant_id_q;
    assign busy             = busy_c;
    assign xfer_count       = xfer_count_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single packet, round-robin with
// burst cap, backpressure, disable, and counter edge cases.
module tb_fifo_wr_arbiter;

    logic        ACLK;
    logic        ARESET;
    logic        fifo_enable;
    logic        cnt_clr;
    logic [1:0]  grant_id;
    logic        busy;
    logic [31:0] xfer_count;
    logic        dbg_state;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus_if ();

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .fifo_enable (fifo_enable),
        .cnt_clr     (cnt_clr),
        .bus         (bus_if),
        .grant_id    (grant_id),
        .busy        (busy),
        .xfer_count  (xfer_count),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Let combinational outputs settle, then check the push gating invariant.
    task automatic settle();
        #1;
        check("push_gate", 32'(bus_if.fifo_wr_en & (bus_if.fifo_full | ~fifo_enable)), 32'd0);
    endtask

    task automatic set_data(input int p, input logic [31:0] d);
        bus_if.req_data[p*32 +: 32] = d;
    endtask

    task automatic chk_bus(input string tag, input logic [3:0] rdy, input logic wr,
                           input logic bsy, input logic [1:0] gid);
        check({tag, ".ready"}, 32'(bus_if.req_ready), 32'(rdy));
        check({tag, ".wr_en"}, 32'(bus_if.fifo_wr_en), 32'(wr));
        check({tag, ".busy"},  32'(busy), 32'(bsy));
        check({tag, ".gid"},   32'(grant_id), 32'(gid));
    endtask

    initial begin
        int pos;
        int b;
        int gid;
        int exp_cnt;

        // ---------- 1: reset then idle ----------
        ARESET             = 1'b1;
        fifo_enable        = 1'b1;
        cnt_clr            = 1'b0;
        bus_if.req_valid   = 4'hF;
        bus_if.req_last    = 4'h0;
        bus_if.fifo_full   = 1'b0;
        for (int i = 0; i < 4; i++) set_data(i, 32'h1000_0000 + i);
        repeat (5) tick();
        settle();
        chk_bus("rst", 4'b0000, 1'b0, 1'b0, 2'd0);
        check("rst.count", xfer_count, 32'd0);
        check("rst.state", 32'(dbg_state), 32'd0);
        check("rst.data", bus_if.fifo_data_in, 32'd0);
        ARESET = 1'b0;
        settle();
        check("post_rst.busy", 32'(busy), 32'd0);
        tick();
        settle();
        chk_bus("first_grant", 4'b0001, 1'b1, 1'b1, 2'd0);
        check("first_grant.data", bus_if.fifo_data_in, 32'h1000_0000);
        bus_if.req_valid = 4'h0;
        settle();
        check("first_grant.drop_wr", 32'(bus_if.fifo_wr_en), 32'd0);
        tick();
        settle();
        check("first_grant.release", 32'(busy), 32'd0);
        check("first_grant.count", xfer_count, 32'd0);

        // ---------- 2: single packet from producer 2 ----------
        bus_if.req_valid = 4'b0100;
        set_data(2, 32'hA1);
        settle();
        tick();
        settle();
        chk_bus("pkt.w1", 4'b0100, 1'b1, 1'b1, 2'd2);
        check("pkt.w1.data", bus_if.fifo_data_in, 32'hA1);
        tick();
        set_data(2, 32'hA2);
        settle();
        check("pkt.w2.wr", 32'(bus_if.fifo_wr_en), 32'd1);
        check("pkt.w2.data", bus_if.fifo_data_in, 32'hA2);
        check("pkt.w2.count", xfer_count, 32'd1);
        tick();
        set_data(2, 32'hA3);
        bus_if.req_last = 4'b0100;
        settle();
        check("pkt.w3.wr", 32'(bus_if.fifo_wr_en), 32'd1);
        check("pkt.w3.data", bus_if.fifo_data_in, 32'hA3);
        check("pkt.w3.count", xfer_count, 32'd2);
        tick();
        bus_if.req_valid = 4'h0;
        bus_if.req_last  = 4'h0;
        settle();
        chk_bus("pkt.end", 4'b0000, 1'b0, 1'b0, 2'd2);
        check("pkt.end.count", xfer_count, 32'd3);
        check("pkt.end.state", 32'(dbg_state), 32'd0);

        // ---------- 3: round-robin and burst cap (fresh reset, last_grant=3) ----------
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        for (int i = 0; i < 4; i++) set_data(i, 32'hB000_0000 + i);
        bus_if.req_valid = 4'hF;
        settle();
        check("rr.pre.count", xfer_count, 32'd0);
        tick();
        for (int k = 0; k < 25; k++) begin
            settle();
            pos     = k % 5;
            b       = k / 5;
            gid     = b % 4;
            exp_cnt = 4 * b + ((pos < 4) ? pos : 4);
            check("rr.gid", 32'(grant_id), 32'(gid));
            check("rr.wr_en", 32'(bus_if.fifo_wr_en), (pos < 4) ? 32'd1 : 32'd0);
            check("rr.busy", 32'(busy), (pos < 4) ? 32'd1 : 32'd0);
            check("rr.ready", 32'(bus_if.req_ready), (pos < 4) ? (32'd1 << gid) : 32'd0);
            check("rr.count", xfer_count, 32'(exp_cnt));
            if (pos < 4) check("rr.data", bus_if.fifo_data_in, 32'hB000_0000 + 32'(gid));
            if (k == 24) bus_if.req_valid = 4'h0;
            tick();
        end
        settle();
        check("rr.total", xfer_count, 32'd20);
        check("rr.idle", 32'(busy), 32'd0);

        // ---------- 4: backpressure on producer 1 ----------
        set_data(1, 32'hC1);
        bus_if.req_valid = 4'b0010;
        settle();
        tick();
        settle();
        chk_bus("bp.w1", 4'b0010, 1'b1, 1'b1, 2'd1);
        check("bp.w1.data", bus_if.fifo_data_in, 32'hC1);
        tick();
        set_data(1, 32'hC2);
        bus_if.fifo_full = 1'b1;
        for (int f = 0; f < 6; f++) begin
            settle();
            chk_bus("bp.stall", 4'b0000, 1'b0, 1'b1, 2'd1);
            check("bp.stall.data", bus_if.fifo_data_in, 32'hC2);
            check("bp.stall.count", xfer_count, 32'd21);
            tick();
        end
        bus_if.fifo_full = 1'b0;
        settle();
        chk_bus("bp.resume", 4'b0010, 1'b1, 1'b1, 2'd1);
        check("bp.resume.data", bus_if.fifo_data_in, 32'hC2);
        tick();
        set_data(1, 32'hC3);
        bus_if.req_last = 4'b0010;
        settle();
        check("bp.w3.data", bus_if.fifo_data_in, 32'hC3);
        check("bp.w3.count", xfer_count, 32'd22);
        tick();
        bus_if.req_valid = 4'h0;
        bus_if.req_last  = 4'h0;
        settle();
        check("bp.end.busy", 32'(busy), 32'd0);
        check("bp.end.count", xfer_count, 32'd23);

        // ---------- 5: disable while producer 3 owns ----------
        set_data(3, 32'hD1);
        bus_if.req_valid = 4'b1000;
        settle();
        tick();
        settle();
        chk_bus("dis.grant", 4'b1000, 1'b1, 1'b1, 2'd3);
        fifo_enable = 1'b0;
        settle();
        chk_bus("dis.gated", 4'b0000, 1'b0, 1'b1, 2'd3);
        tick();
        settle();
        check("dis.release", 32'(busy), 32'd0);
        check("dis.count", xfer_count, 32'd23);
        bus_if.req_valid = 4'hF;
        tick();
        settle();
        check("dis.hold1", 32'(busy), 32'd0);
        tick();
        settle();
        chk_bus("dis.hold2", 4'b0000, 1'b0, 1'b0, 2'd3);
        fifo_enable = 1'b1;
        settle();
        tick();
        settle();
        check("dis.resume.busy", 32'(busy), 32'd1);
        check("dis.resume.gid", 32'(grant_id), 32'd0);
        bus_if.req_valid = 4'h0;
        tick();
        settle();
        check("dis.resume.release", 32'(busy), 32'd0);
        check("dis.resume.count", xfer_count, 32'd23);

        // ---------- 6: counter edges and reset mid-burst ----------
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        settle();
        check("clr.idle", xfer_count, 32'd0);

        force dut.xfer_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.xfer_count_q;
        settle();
        check("wrap.preload", xfer_count, 32'hFFFF_FFFF);
        set_data(1, 32'hE1);
        bus_if.req_valid = 4'b0010;
        bus_if.req_last  = 4'b0010;
        tick();
        settle();
        check("wrap.wr", 32'(bus_if.fifo_wr_en), 32'd1);
        check("wrap.gid", 32'(grant_id), 32'd1);
        tick();
        bus_if.req_valid = 4'h0;
        bus_if.req_last  = 4'h0;
        settle();
        check("wrap.count", xfer_count, 32'd0);
        check("wrap.busy", 32'(busy), 32'd0);

        set_data(1, 32'hE2);
        bus_if.req_valid = 4'b0010;
        tick();
        settle();
        check("clrx.grant", 32'(grant_id), 32'd1);
        tick();
        settle();
        check("clrx.c1", xfer_count, 32'd1);
        tick();
        bus_if.req_last = 4'b0010;
        cnt_clr = 1'b1;
        settle();
        check("clrx.c2", xfer_count, 32'd2);
        check("clrx.wr", 32'(bus_if.fifo_wr_en), 32'd1);
        tick();
        cnt_clr          = 1'b0;
        bus_if.req_valid = 4'h0;
        bus_if.req_last  = 4'h0;
        settle();
        check("clrx.count", xfer_count, 32'd1);
        check("clrx.busy", 32'(busy), 32'd0);

        set_data(2, 32'hF1);
        bus_if.req_valid = 4'b0100;
        tick();
        settle();
        chk_bus("arst.pre", 4'b0100, 1'b1, 1'b1, 2'd2);
        ARESET = 1'b1;
        settle();
        chk_bus("arst", 4'b0000, 1'b0, 1'b0, 2'd0);
        check("arst.data", bus_if.fifo_data_in, 32'd0);
        check("arst.count", xfer_count, 32'd0);
        check("arst.state", 32'(dbg_state), 32'd0);
        tick();
        ARESET = 1'b0;
        bus_if.req_valid = 4'h0;
        settle();
        check("arst.after", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
